timer_counter: RTL and testbench
================================

# timer_counter

Free-running binary up-counter that exposes its most-significant bits as a slowly changing output word. Each output bit toggles at a power-of-two division of the system clock. It is used to blink or cycle board LEDs (e.g. an RGB LED driven from bits 2/1/0) and as a generic clock-derived slow strobe source. It sits directly between the chip clock and LED/indicator logic, with no handshake.

## Interface
- `WIDTH`, default 5: total counter width in bits; must be at least 1.
- `BITS`, default 3: number of output bits taken from the counter MSBs; must satisfy 1 ≤ BITS ≤ WIDTH.
- `i_clk`  in  1: system clock; all state changes on its rising edge.
- `i_rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `o_data`  out  BITS: counter bits [WIDTH-1 : WIDTH-BITS], so `o_data[BITS-1]` is the counter MSB.
- `o_wrap`  out  1: high for exactly one cycle while the counter holds its all-ones value 2^WIDTH−1.

## Operation
- Internal register `count[WIDTH-1:0]`.
- On each rising `i_clk`:
  - if `i_rst` is 1: `count <= 0`.
  - otherwise: `count <= count + 1`, modulo 2^WIDTH.
- Counting is unconditional. There is no enable and no load.
- Wrap-around: after 2^WIDTH−1 the next value is 0. There is no sticky flag and no stall.
- `o_data = count[WIDTH-1 -: BITS]`, a combinational slice of the register, so it is glitch-free.
- `o_wrap = (count == 2^WIDTH−1)`.
- Power-up: `count` is initialised to 0 by register initial value. This gives correct behaviour on FPGA targets even if `i_rst` is never asserted.
- Parameter violations must stop elaboration with a clear error: BITS > WIDTH, BITS < 1, or WIDTH < 1.
- BITS == WIDTH is legal; in that case `o_data` equals `count`.

## Timing
- Reset value of every output: `o_data = 0`, `o_wrap = 0`.
  - Exception: when WIDTH = 1 and the counter is held at 0, `o_wrap` is still 0 because all-ones = 1.
- Reset latency: one edge. The edge that samples `i_rst = 1` yields `count = 0` in the same cycle it is registered.
- First increment: on the first edge after `i_rst` deasserts, `count` goes 0 → 1.
- `o_data` period:
  - it advances once every 2^(WIDTH−BITS) cycles;
  - the full `o_data` sequence 0…2^BITS−1 repeats every 2^WIDTH cycles.
- Bit k of `o_data`, which is counter bit WIDTH−BITS+k, toggles every 2^(WIDTH−BITS+k) cycles.
- Reset asserted mid-count: takes effect on the next edge regardless of the current value, and counting restarts from 0.
- Reset held high keeps `count` at 0 indefinitely.
- `o_wrap` is asserted in the cycle before `count` returns to 0. It is never asserted while reset holds the counter.

## Structure
- Single flat module, no sub-modules.
- No shared package is required. If the team's common package holds a clog2/param-check helper, use it for the BITS ≤ WIDTH assertion.
- Output is a pure slice plus a compare; no extra pipeline registers.

## Test plan
- **Defaults (WIDTH=5, BITS=3), reset 1 cycle then released.** `o_data` holds each of 0,1,…,7 for exactly 4 cycles. It returns to 0 at cycle 32 after release. `o_wrap` is high only at cycle 31.
- **Mid-count reset (defaults).** Release reset, run 13 cycles so `count` = 13 and `o_data` = 3. Assert `i_rst` for 1 cycle. Then `o_data` = 0 and `count` = 0, and the next edge gives `count` = 1.
- **Reset held (defaults).** Hold `i_rst` for 10 cycles: `o_data` stays 0 and `o_wrap` stays 0 throughout. On release, counting resumes from 0.
- **No reset ever asserted (defaults).** Starting from power-up, behaviour matches the first scenario, beginning with `count` = 0 at time 0.
- **BITS == WIDTH (WIDTH=3, BITS=3).** `o_data` steps 0,1,…,7,0 on consecutive cycles. `o_wrap` is high whenever `o_data` = 7.
- **Illegal parameters (WIDTH=2, BITS=3).** Elaboration fails with an error message.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared helpers for the free-running timer counter: parameter legality check.
package timer_counter_pkg;

  function automatic bit params_ok(input int width, input int bits);
    return (width >= 1) && (bits >= 1) && (bits <= width);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Free-running up-counter exposing its top BITS as a slow LED/strobe word,
// plus a one-cycle pulse while the counter sits at all-ones.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int BITS  = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [BITS-1:0] o_data,
  output logic            o_wrap
);

  generate
    if (!params_ok(WIDTH, BITS)) begin : g_bad_params
      $error("timer_counter: illegal parameters WIDTH=%0d BITS=%0d (need 1 <= BITS <= WIDTH)",
             WIDTH, BITS);
    end
  endgenerate

  // Declaration initialiser gives a defined count even if reset never fires.
  logic [WIDTH-1:0] count_reg = '0;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg + WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign o_data = count_reg[WIDTH-1 -: BITS];
  assign o_wrap = &count_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Randomised reset stimulus against an arithmetic cycle-count model for three
// instances: defaults with reset, defaults never reset, and BITS == WIDTH.
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_never = 1'b0;
  logic [2:0] data_a, data_nr, data_w3;
  logic       wrap_a, wrap_nr, wrap_w3;

  int checks = 0;
  int errors = 0;

  // Cycles elapsed since the last reset (or since power-up).
  int n_a  = 0;
  int n_nr = 0;

  always #5 clk = ~clk;

  timer_counter #(.WIDTH(5), .BITS(3)) dut_a (
    .i_clk(clk), .i_rst(rst), .o_data(data_a), .o_wrap(wrap_a)
  );

  timer_counter #(.WIDTH(5), .BITS(3)) dut_nr (
    .i_clk(clk), .i_rst(rst_never), .o_data(data_nr), .o_wrap(wrap_nr)
  );

  timer_counter #(.WIDTH(3), .BITS(3)) dut_w3 (
    .i_clk(clk), .i_rst(rst), .o_data(data_w3), .o_wrap(wrap_w3)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs come straight from "count = cycles mod 2^W".
  task automatic check_all(input string phase);
    int c5, c3;
    c5 = n_a % 32;
    c3 = n_a % 8;
    check({phase, " a.data"},  int'(data_a),  c5 / 4);
    check({phase, " a.wrap"},  int'(wrap_a),  (c5 == 31) ? 1 : 0);
    check({phase, " w3.data"}, int'(data_w3), c3);
    check({phase, " w3.wrap"}, int'(wrap_w3), (c3 == 7) ? 1 : 0);
    check({phase, " nr.data"}, int'(data_nr), (n_nr % 32) / 4);
    check({phase, " nr.wrap"}, int'(wrap_nr), ((n_nr % 32) == 31) ? 1 : 0);
  endtask

  task automatic step(input bit r, input string phase);
    rst = r;
    @(posedge clk);
    n_a  = r ? 0 : n_a + 1;
    n_nr = n_nr + 1;
    #1;
    check_all(phase);
  endtask

  initial begin
    int burst;
    // Power-up: every counter starts at zero without any reset.
    #1;
    check_all("powerup");

    // One-cycle reset, then a full wrap plus a bit.
    step(1'b1, "rst1");
    for (int i = 0; i < 40; i++) step(1'b0, "run");

    // Mid-count reset at count 13.
    step(1'b1, "rst2");
    for (int i = 0; i < 13; i++) step(1'b0, "to13");
    check("mid data=3", int'(data_a), 3);
    step(1'b1, "midrst");
    step(1'b0, "after_midrst");

    // Reset held for 10 cycles, then resume.
    for (int i = 0; i < 10; i++) step(1'b1, "held");
    for (int i = 0; i < 8; i++) step(1'b0, "resume");

    // Random reset pulses and bursts.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        burst = $urandom_range(1, 4);
        for (int j = 0; j < burst; j++) step(1'b1, "rnd_rst");
      end else begin
        step(1'b0, "rnd_run");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
